// File: rtl/invader_formation_if.sv
// Player-projectile handshake between the player logic (master) and the
// invader formation (slave): shot position in, kill pulse and consume out.
interface invader_formation_if;
    logic       shot_valid;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    logic       hit;
    logic       shot_consume;

    modport master (output shot_valid, shot_x, shot_y, input  hit, shot_consume);
    modport slave  (input  shot_valid, shot_x, shot_y, output hit, shot_consume);
endinterface

// File: rtl/invader_formation.sv
// Invader formation: marching/descending column block, shot collision and scoring,
// and one enemy projectile slot per column.
module invader_formation #(
    parameter int N_COLS     = 5,
    parameter int SPACING    = 40,
    parameter int X_START    = 100,
    parameter int X_MIN      = 96,
    parameter int X_MAX      = 389,
    parameter int Y_START    = 10,
    parameter int Y_STEP     = 10,
    parameter int Y_LAND     = 400,
    parameter int HIT_W      = 15,
    parameter int HIT_H      = 20,
    parameter int SCORE_PTS  = 50,
    parameter int FIRE_DIV   = 8,
    parameter int PROJ_SPEED = 1
) (
    input  logic                  dclk,
    input  logic                  clr_n,
    input  logic                  tick_i,
    input  logic                  play_i,
    input  logic [7:0]            rand_i,
    invader_formation_if.slave    shot_if,
    output logic [9:0]            inv_x_o,
    output logic [9:0]            inv_y_o,
    output logic [N_COLS-1:0]     alive_o,
    output logic [13:0]           score_o,
    output logic [10*N_COLS-1:0]  eproj_x_o,
    output logic [10*N_COLS-1:0]  eproj_y_o,
    output logic [N_COLS-1:0]     eproj_active_o,
    output logic                  wave_clear_o,
    output logic                  landed_o
);

    localparam int FW = (FIRE_DIV > 1) ? $clog2(FIRE_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_MARCH, S_DESCEND, S_CLEARED, S_LANDED} state_t;

    state_t                   state_q, state_d;
    logic [9:0]               inv_x_q, inv_x_d;
    logic [9:0]               inv_y_q, inv_y_d;
    logic [N_COLS-1:0]        alive_q, alive_d;
    logic                     dir_left_q, dir_left_d;
    logic                     phase_q, phase_d;
    logic [13:0]              score_q, score_d;
    logic                     hit_q, hit_d;
    logic [FW-1:0]            fire_cnt_q, fire_cnt_d;
    logic [5:0]               clr_cnt_q, clr_cnt_d;
    logic [N_COLS-1:0][9:0]   eproj_x_q, eproj_x_d;
    logic [N_COLS-1:0][9:0]   eproj_y_q, eproj_y_d;
    logic [N_COLS-1:0]        eproj_active_q, eproj_active_d;

    logic [N_COLS-1:0]        hit_vec;
    logic [N_COLS-1:0]        kill_vec;
    logic [7:0]               fire_sel;

    function automatic logic [10:0] colx(input logic [9:0] x, input int unsigned c);
        return {1'b0, x} + 11'(c * SPACING);
    endfunction

    assign fire_sel = rand_i % 8'(N_COLS);

    always_comb begin
        logic [10:0]        cx;
        logic signed [11:0] dx;
        logic [11:0]        adx;
        hit_vec = '0;
        for (int unsigned c = 0; c < N_COLS; c++) begin
            cx  = colx(inv_x_q, c);
            dx  = $signed({2'b00, shot_if.shot_x}) - $signed({1'b0, cx});
            adx = dx[11] ? 12'(-dx) : 12'(dx);
            if (alive_q[c] && shot_if.shot_valid && (shot_if.shot_y > inv_y_q) &&
                ((shot_if.shot_y - inv_y_q) < 10'(HIT_H)) && (adx < 12'(HIT_W)))
                hit_vec[c] = 1'b1;
        end
        if (!(state_q == S_MARCH || state_q == S_DESCEND))
            hit_vec = '0;
    end

    // Isolate the lowest set bit so only one column dies per cycle.
    assign kill_vec = hit_vec & (~hit_vec + N_COLS'(1));

    always_comb begin
        logic        do_reload;
        logic        clear_proj;
        logic        proj_run;
        logic        fire_now;
        logic [10:0] ny;
        logic [10:0] cx;
        logic [14:0] sc;

        state_d        = state_q;
        inv_x_d        = inv_x_q;
        inv_y_d        = inv_y_q;
        alive_d        = alive_q;
        dir_left_d     = dir_left_q;
        phase_d        = phase_q;
        score_d        = score_q;
        hit_d          = 1'b0;
        fire_cnt_d     = fire_cnt_q;
        clr_cnt_d      = clr_cnt_q;
        eproj_x_d      = eproj_x_q;
        eproj_y_d      = eproj_y_q;
        eproj_active_d = eproj_active_q;
        do_reload      = 1'b0;
        clear_proj     = 1'b0;
        proj_run       = 1'b0;
        fire_now       = 1'b0;
        ny             = '0;
        cx             = '0;
        sc             = '0;

        if (!play_i) begin
            state_d    = S_IDLE;
            do_reload  = 1'b1;
            clear_proj = 1'b1;
            clr_cnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    do_reload  = 1'b1;
                    clear_proj = 1'b1;
                    score_d    = '0;
                    clr_cnt_d  = '0;
                    state_d    = S_MARCH;
                end
                S_MARCH, S_DESCEND: begin
                    proj_run = 1'b1;
                    if (alive_q == '0) begin
                        state_d   = S_CLEARED;
                        clr_cnt_d = '0;
                    end else begin
                        if (tick_i)
                            phase_d = ~phase_q;
                        if (tick_i && phase_q) begin
                            if (state_q == S_MARCH) begin
                                if (dir_left_q ? (inv_x_q <= 10'(X_MIN)) : (inv_x_q >= 10'(X_MAX)))
                                    state_d = S_DESCEND;
                                else
                                    inv_x_d = dir_left_q ? inv_x_q - 10'd1 : inv_x_q + 10'd1;
                            end else begin
                                ny         = {1'b0, inv_y_q} + 11'(Y_STEP);
                                inv_y_d    = ny[9:0];
                                dir_left_d = ~dir_left_q;
                                state_d    = (ny >= 11'(Y_LAND)) ? S_LANDED : S_MARCH;
                            end
                        end
                        if (kill_vec != '0) begin
                            alive_d = alive_q & ~kill_vec;
                            hit_d   = 1'b1;
                            sc      = {1'b0, score_q} + 15'(SCORE_PTS);
                            score_d = (sc > 15'd9999) ? 14'd9999 : sc[13:0];
                        end
                        if (tick_i) begin
                            if (fire_cnt_q == FW'(FIRE_DIV - 1)) begin
                                fire_cnt_d = '0;
                                fire_now   = 1'b1;
                            end else begin
                                fire_cnt_d = fire_cnt_q + FW'(1);
                            end
                        end
                    end
                end
                S_CLEARED: begin
                    proj_run = 1'b1;
                    if (tick_i) begin
                        if (clr_cnt_q == 6'd63) begin
                            clr_cnt_d = '0;
                            do_reload = 1'b1;
                            state_d   = S_MARCH;
                        end else begin
                            clr_cnt_d = clr_cnt_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (do_reload) begin
            inv_x_d    = 10'(X_START);
            inv_y_d    = 10'(Y_START);
            alive_d    = '1;
            dir_left_d = 1'b0;
            phase_d    = 1'b0;
            fire_cnt_d = '0;
        end

        // Loading is applied after motion so a same-tick load overrides the move.
        for (int unsigned c = 0; c < N_COLS; c++) begin
            if (proj_run && tick_i && eproj_active_q[c]) begin
                ny = {1'b0, eproj_y_q[c]} + 11'(PROJ_SPEED);
                if (ny > 11'd479) begin
                    eproj_active_d[c] = 1'b0;
                    eproj_y_d[c]      = '0;
                end else begin
                    eproj_y_d[c] = ny[9:0];
                end
            end
            if (fire_now && (32'(fire_sel) == c) && alive_q[c] && !eproj_active_q[c]) begin
                cx                = colx(inv_x_q, c);
                eproj_x_d[c]      = cx[9:0];
                eproj_y_d[c]      = inv_y_q + 10'(HIT_H);
                eproj_active_d[c] = 1'b1;
            end
        end

        if (clear_proj)
            eproj_active_d = '0;
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= S_IDLE;
            inv_x_q        <= 10'(X_START);
            inv_y_q        <= 10'(Y_START);
            alive_q        <= '1;
            dir_left_q     <= 1'b0;
            phase_q        <= 1'b0;
            score_q        <= '0;
            hit_q          <= 1'b0;
            fire_cnt_q     <= '0;
            clr_cnt_q      <= '0;
            eproj_x_q      <= '0;
            eproj_y_q      <= '0;
            eproj_active_q <= '0;
        end else begin
            state_q        <= state_d;
            inv_x_q        <= inv_x_d;
            inv_y_q        <= inv_y_d;
            alive_q        <= alive_d;
            dir_left_q     <= dir_left_d;
            phase_q        <= phase_d;
            score_q        <= score_d;
            hit_q          <= hit_d;
            fire_cnt_q     <= fire_cnt_d;
            clr_cnt_q      <= clr_cnt_d;
            eproj_x_q      <= eproj_x_d;
            eproj_y_q      <= eproj_y_d;
            eproj_active_q <= eproj_active_d;
        end
    end

    assign inv_x_o              = inv_x_q;
    assign inv_y_o              = inv_y_q;
    assign alive_o              = alive_q;
    assign score_o              = score_q;
    assign eproj_x_o            = eproj_x_q;
    assign eproj_y_o            = eproj_y_q;
    assign eproj_active_o       = eproj_active_q;
    assign wave_clear_o         = (state_q == S_CLEARED);
    assign landed_o             = (state_q == S_LANDED);
    assign shot_if.hit          = hit_q;
    assign shot_if.shot_consume = hit_q;

endmodule

// File: tb/tb_invader_formation.sv
// Directed bench for invader_formation: march/descend timing, collisions, fire,
// wave clear and asynchronous reset, with a narrow-spacing instance for overlap hits.
module tb_invader_formation;

    logic        dclk = 1'b0;
    logic        clr_n;
    logic        tick;
    logic        play;
    logic [7:0]  rnd;

    logic [9:0]  inv_x, inv_y, inv_x2, inv_y2;
    logic [4:0]  alive, alive2, eact, eact2;
    logic [13:0] score, score2;
    logic [49:0] ex, ey, ex2, ey2;
    logic        wclr, landed, wclr2, landed2;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    invader_formation_if sif ();
    invader_formation_if sif2 ();

    always #5 dclk = ~dclk;

    invader_formation dut (
        .dclk(dclk), .clr_n(clr_n), .tick_i(tick), .play_i(play), .rand_i(rnd),
        .shot_if(sif.slave), .inv_x_o(inv_x), .inv_y_o(inv_y), .alive_o(alive),
        .score_o(score), .eproj_x_o(ex), .eproj_y_o(ey), .eproj_active_o(eact),
        .wave_clear_o(wclr), .landed_o(landed)
    );

    invader_formation #(.SPACING(20)) dut2 (
        .dclk(dclk), .clr_n(clr_n), .tick_i(tick), .play_i(play), .rand_i(rnd),
        .shot_if(sif2.slave), .inv_x_o(inv_x2), .inv_y_o(inv_y2), .alive_o(alive2),
        .score_o(score2), .eproj_x_o(ex2), .eproj_y_o(ey2), .eproj_active_o(eact2),
        .wave_clear_o(wclr2), .landed_o(landed2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    task automatic do_reset();
        play  = 1'b0;
        clr_n = 1'b0;
        step(2);
        clr_n = 1'b1;
        step(1);
    endtask

    task automatic shoot(input logic [9:0] x, input logic [9:0] y);
        sif.shot_x     = x;
        sif.shot_y     = y;
        sif.shot_valid = 1'b1;
        step(1);
    endtask

    initial begin
        clr_n = 1'b0; play = 1'b0; tick = 1'b1; rnd = 8'd0;
        sif.shot_valid  = 1'b0; sif.shot_x  = '0; sif.shot_y  = '0;
        sif2.shot_valid = 1'b0; sif2.shot_x = '0; sif2.shot_y = '0;
        #12;
        check("rst_inv_x", inv_x, 100);
        check("rst_inv_y", inv_y, 10);
        check("rst_alive", alive, 5'b11111);
        check("rst_score", score, 0);
        check("rst_eact", eact, 0);
        check("rst_hit", sif.hit, 0);
        check("rst_wclr", wclr, 0);
        check("rst_landed", landed, 0);
        clr_n = 1'b1;
        step(1);

        // March to the right edge, descend, then head left.
        play = 1'b1; tick = 1'b1; rnd = 8'd0;
        step(1);  check("march_start_x", inv_x, 100);
        step(2);  check("march_first_move", inv_x, 101);
        step(576); check("march_right_edge", inv_x, 389);
        check("march_y_before", inv_y, 10);
        step(2);  check("edge_hold_x", inv_x, 389);
        check("edge_hold_y", inv_y, 10);
        step(2);  check("descend_y", inv_y, 20);
        check("descend_x", inv_x, 389);
        step(2);  check("march_left", inv_x, 388);

        // Enemy fire: rand=7 selects column 2.
        do_reset();
        play = 1'b1; tick = 1'b1; rnd = 8'd7;
        step(9);
        check("fire_active", eact, 5'b00100);
        check("fire_x", ex[29:20], 183);
        check("fire_y", ey[29:20], 30);
        step(1);  check("proj_move", ey[29:20], 31);
        step(448); check("proj_last_row", ey[29:20], 479);
        check("proj_last_act", eact, 5'b00100);
        step(1);  check("proj_off_act", eact, 0);
        check("proj_off_y", ey[29:20], 0);

        // Collisions with motion frozen, then wave clear.
        do_reset();
        play = 1'b1; tick = 1'b0; rnd = 8'd0;
        step(1);
        sif2.shot_x = 10'd110; sif2.shot_y = 10'd20; sif2.shot_valid = 1'b1;
        shoot(10'd145, 10'd25);
        check("kill1_alive", alive, 5'b11101);
        check("kill1_hit", sif.hit, 1);
        check("kill1_consume", sif.shot_consume, 1);
        check("kill1_score", score, 50);
        check("overlap_alive", alive2, 5'b11110);
        check("overlap_score", score2, 50);
        check("overlap_hit", sif2.hit, 1);
        sif2.shot_valid = 1'b0;
        shoot(10'd115, 10'd25);
        check("xwin_miss_alive", alive, 5'b11101);
        check("hit_pulse_end", sif.hit, 0);
        shoot(10'd100, 10'd30);
        check("ywin_miss_alive", alive, 5'b11101);
        shoot(10'd100, 10'd10);
        check("above_miss_alive", alive, 5'b11101);
        shoot(10'd114, 10'd29);
        check("edge_kill_alive", alive, 5'b11100);
        check("edge_kill_score", score, 100);
        shoot(10'd180, 10'd20);
        shoot(10'd220, 10'd20);
        shoot(10'd260, 10'd20);
        check("all_dead_alive", alive, 0);
        check("all_dead_score", score, 250);
        sif.shot_valid = 1'b0;
        step(1);  check("cleared_flag", wclr, 1);
        tick = 1'b1;
        step(63); check("cleared_hold", wclr, 1);
        step(1);
        check("restore_wclr", wclr, 0);
        check("restore_alive", alive, 5'b11111);
        check("restore_x", inv_x, 100);
        check("restore_y", inv_y, 10);
        check("restore_score", score, 250);
        play = 1'b0;
        step(1);  check("idle_score_held", score, 250);
        check("idle_x", inv_x, 100);
        play = 1'b1;
        step(1);  check("restart_score", score, 0);

        // Asynchronous reset with a projectile in flight.
        do_reset();
        play = 1'b1; tick = 1'b0;
        step(1);
        shoot(10'd145, 10'd25);
        shoot(10'd114, 10'd29);
        shoot(10'd180, 10'd20);
        check("pre_reset_score", score, 150);
        sif.shot_valid = 1'b0; tick = 1'b1; rnd = 8'd4;
        step(8);
        check("pre_reset_eact", eact, 5'b10000);
        #3 clr_n = 1'b0;
        #1;
        check("async_score", score, 0);
        check("async_eact", eact, 0);
        check("async_ex", ex, 0);
        check("async_ey", ey, 0);
        check("async_alive", alive, 5'b11111);
        check("async_x", inv_x, 100);
        check("async_y", inv_y, 10);
        check("async_wclr", wclr, 0);
        check("async_hit", sif.hit, 0);
        clr_n = 1'b1;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/invader_formation.md
INVADER_FORMATION -- requirements
Module: invader_formation

Interface
REQ-001 SHALL have parameter N_COLS, default 5, number of invader columns (1..8).
REQ-002 SHALL have parameter SPACING, default 40, x pitch between columns.
REQ-003 SHALL have parameters X_START=100, X_MIN=96, X_MAX=389 (left-column x bounds), Y_START=10, Y_STEP=10, Y_LAND=400.
REQ-004 SHALL have parameters HIT_W=15 (x half-window), HIT_H=20, SCORE_PTS=50, FIRE_DIV=8 (ticks per fire attempt), PROJ_SPEED=1.
REQ-005 SHALL have ports (one per line):
- dclk  in  1  clock.
- clr_n  in  1  reset, asynchronous, active-low.
- tick  in  1  game-time enable; all motion advances only on cycles with tick=1.
- play  in  1  game running.
- rand  in  8  random source.
- shot_valid  in  1  player projectile present.
- shot_x, shot_y  in  10 each  player projectile position.
- inv_x, inv_y  out  10 each  column-0 position.
- alive  out  N_COLS  per-column alive mask.
- hit  out  1  one-cycle pulse on any kill.
- shot_consume  out  1  same cycle as hit; player deletes its projectile.
- score  out  14  accumulated score.
- eproj_x, eproj_y  out  10*N_COLS each  packed enemy projectile positions, slot c at [10c+9:10c].
- eproj_active  out  N_COLS  per-slot in-flight flag.
- wave_clear  out  1  high in CLEARED.
- landed  out  1  high in LANDED.

Function
REQ-006 SHALL implement states IDLE, MARCH, DESCEND, CLEARED, LANDED.
REQ-007 IDLE: inv_x=X_START, inv_y=Y_START, alive all ones, direction right, eproj_active=0; play=1 -> MARCH next cycle with score cleared to 0.
REQ-008 play=0 in any state SHALL force IDLE next cycle; score holds until the next IDLE->MARCH.
REQ-009 MARCH: a move phase bit toggles each tick; on tick with phase=1, inv_x +/-1 per direction.
REQ-010 MARCH: on a move tick with inv_x>=X_MAX (right) or inv_x<=X_MIN (left), x SHALL not change; state -> DESCEND.
REQ-011 DESCEND: next move tick, inv_y += Y_STEP, direction flips, state -> MARCH; if new inv_y >= Y_LAND, state -> LANDED instead.
REQ-012 Column c x position SHALL be inv_x + c*SPACING, computed in 11-bit unsigned arithmetic.
REQ-013 Collision, evaluated every cycle (not tick-gated) in MARCH/DESCEND: column c hit if alive[c] & shot_valid & shot_y>inv_y & (shot_y-inv_y)<HIT_H & |shot_x-colx(c)|<HIT_W, signed 12-bit compare.
REQ-014 Multiple columns hit in one cycle: only the lowest index is killed; hit, shot_consume pulse one cycle later; alive[c] clears same edge.
REQ-015 Each kill SHALL add SCORE_PTS to score, saturating at 9999.
REQ-016 When alive becomes all zeros, state -> CLEARED next cycle; CLEARED counts 64 ticks, then reloads IDLE formation values (score kept) and returns to MARCH.
REQ-017 Fire: counter increments per tick in MARCH/DESCEND; on wrap at FIRE_DIV, c = rand mod N_COLS; if alive[c] & !eproj_active[c], slot c loads x=colx(c), y=inv_y+HIT_H, active=1.
REQ-018 Each tick, active slots SHALL add PROJ_SPEED to y; if result >479, slot clears (active=0, y=0).
REQ-019 Load and move on the same tick for one slot: load wins.
REQ-020 A slot in flight SHALL continue after its column dies; new loads blocked for dead columns.
REQ-021 LANDED: motion, firing, collision frozen; landed=1 until play=0.
REQ-022 Simultaneous kill and move tick SHALL apply both.

Reset
REQ-023 clr_n low SHALL immediately force IDLE, inv_x=X_START, inv_y=Y_START, alive all ones, score=0, eproj_x/y=0, eproj_active=0, hit=shot_consume=wave_clear=landed=0, direction right, counters 0.
REQ-024 Reset mid-flight SHALL discard all projectiles; release enters IDLE, not MARCH, until play is sampled.

Verification
REQ-025 play=1, tick every cycle, no shots -> inv_x 100->389 in 578 ticks, DESCEND, inv_y=20, then moves left.
REQ-026 inv_x=100, inv_y=10, shot (145,25) valid -> column 1 killed, alive=5'b11101, hit one cycle, score=50.
REQ-027 shot hitting columns 0 and 1 boundaries simultaneously -> only alive[0] clears, score +50.
REQ-028 rand=7, N_COLS=5, fire wrap -> slot 2 loads x=inv_x+80, y=inv_y+20; reaches y>479 -> active=0.
REQ-029 kill all five columns -> wave_clear high, 64 ticks later formation restored at (100,10), score 250 retained.
REQ-030 clr_n low during flight with score 150 -> all outputs to reset values within same cycle, asynchronously.
